// File: rtl/ahtbe_rate_shaper.sv
// Token-bucket shaper: buffers producer telemetry beats in a small FIFO and
// releases them at a rate steered by queue-monitor backpressure and level.
module ahtbe_rate_shaper #(
  parameter int unsigned DW            = 16,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned TOKEN_MAX     = 8,
  parameter int unsigned TICK_DIV      = 4,
  parameter int unsigned RATE_NORM     = 2,
  parameter int unsigned RATE_THR      = 1,
  parameter int unsigned RECOVER_TICKS = 4,
  parameter int unsigned HARD_LIMIT    = 32
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [DW-1:0]                      in_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [DW-1:0]                      out_data,
  input  logic                               backpressure,
  input  logic [7:0]                         queue_level,
  output logic [1:0]                         mode,
  output logic [$clog2(TOKEN_MAX+1)-1:0]     tokens,
  output logic [$clog2(FIFO_DEPTH):0]        fifo_count
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned TW = $clog2(TOKEN_MAX + 1);
  localparam int unsigned KW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned RW = (RECOVER_TICKS > 1) ? $clog2(RECOVER_TICKS + 1) : 1;

  typedef enum logic [1:0] {
    NORMAL   = 2'd0,
    THROTTLE = 2'd1,
    HOLD     = 2'd2
  } mode_e;

  logic [DW-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [TW-1:0] tokens_q, tokens_d;
  logic [KW-1:0] tick_q, tick_d;
  logic          committed_q, committed_d;
  mode_e         mode_q;
  logic [RW-1:0] rec_q;

  logic          push;
  logic          pop;
  logic          tick;
  logic          eligible;
  logic [31:0]   add;
  logic [31:0]   tok_sum;

  assign in_ready   = (count_q < CW'(FIFO_DEPTH));
  assign eligible   = (count_q != '0) && (tokens_q != '0) && (mode_q != HOLD);
  assign out_valid  = committed_q || eligible;
  assign out_data   = mem_q[rd_ptr_q];
  assign push       = in_valid && in_ready;
  assign pop        = out_valid && out_ready;
  assign tick       = (tick_q == KW'(TICK_DIV - 1));
  assign mode       = 2'(mode_q);
  assign tokens     = tokens_q;
  assign fifo_count = count_q;

  // FIFO bookkeeping, refill timing and token arithmetic
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    committed_d = out_valid && !out_ready;
    tick_d      = tick ? '0 : tick_q + KW'(1);
    add         = 32'd0;

    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (tick) begin
      case (mode_q)
        NORMAL:   add = RATE_NORM;
        THROTTLE: add = RATE_THR;
        default:  add = 32'd0;
      endcase
    end
    // A pop always holds at least one token, so this never underflows
    tok_sum  = 32'(tokens_q) + add - 32'(pop);
    tokens_d = (tok_sum > TOKEN_MAX) ? TW'(TOKEN_MAX) : TW'(tok_sum);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      tokens_q    <= TW'(TOKEN_MAX);
      tick_q      <= '0;
      committed_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      tokens_q    <= tokens_d;
      tick_q      <= tick_d;
      committed_q <= committed_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  // Mode FSM; a hard queue level overrides everything else
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q <= NORMAL;
      rec_q  <= '0;
    end else if (32'(queue_level) >= HARD_LIMIT) begin
      mode_q <= HOLD;
      rec_q  <= '0;
    end else begin
      case (mode_q)
        NORMAL: begin
          rec_q <= '0;
          if (backpressure) mode_q <= THROTTLE;
        end
        THROTTLE: begin
          if (backpressure) begin
            rec_q <= '0;
          end else if (tick) begin
            if (32'(rec_q) + 32'd1 >= RECOVER_TICKS) begin
              mode_q <= NORMAL;
              rec_q  <= '0;
            end else begin
              rec_q <= rec_q + RW'(1);
            end
          end
        end
        HOLD: begin
          if (32'(queue_level) < HARD_LIMIT / 2) begin
            mode_q <= THROTTLE;
            rec_q  <= '0;
          end
        end
        default: begin
          mode_q <= NORMAL;
          rec_q  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahtbe_rate_shaper.sv
// Directed vector bench for ahtbe_rate_shaper: each row gives this cycle's
// inputs and the outputs expected from the state before the next clock edge.
module tb_ahtbe_rate_shaper;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        backpressure;
  logic [7:0]  queue_level;
  logic [1:0]  mode;
  logic [3:0]  tokens;
  logic [2:0]  fifo_count;

  ahtbe_rate_shaper dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .backpressure (backpressure),
    .queue_level  (queue_level),
    .mode         (mode),
    .tokens       (tokens),
    .fifo_count   (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          seg;
    logic        rst_n;
    logic        iv;
    logic [15:0] id;
    logic        ordy;
    logic        bp;
    logic [7:0]  ql;
    logic        e_ov;
    logic [15:0] e_od;
    logic        e_ir;
    logic [1:0]  e_mode;
    logic [3:0]  e_tok;
    logic [2:0]  e_cnt;
  } vec_t;

  vec_t vecs[$];
  int   n_vec;
  int   n_cmp;
  int   n_bad;

  function automatic logic [15:0] beat(input int n);
    return 16'hA500 + 16'(n);
  endfunction

  task automatic v(input int seg, input int rs, input int iv, input int id,
                   input int ordy, input int bp, input int ql,
                   input int ov, input int od, input int ir, input int md,
                   input int tok, input int cnt);
    vec_t r;
    r.seg = seg; r.rst_n = 1'(rs); r.iv = 1'(iv); r.id = beat(id);
    r.ordy = 1'(ordy); r.bp = 1'(bp); r.ql = 8'(ql);
    r.e_ov = 1'(ov); r.e_od = beat(od); r.e_ir = 1'(ir);
    r.e_mode = 2'(md); r.e_tok = 4'(tok); r.e_cnt = 3'(cnt);
    vecs.push_back(r);
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s vec %0d: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    backpressure = 1'b0; queue_level = '0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_count",  -1, 32'(fifo_count), 32'd0);
    chk("rst_tokens", -1, 32'(tokens),     32'd8);
    chk("rst_mode",   -1, 32'(mode),       32'd0);
    chk("rst_ovalid", -1, 32'(out_valid),  32'd0);
    chk("rst_iready", -1, 32'(in_ready),   32'd1);
  endtask

  initial begin
    n_vec = 0; n_cmp = 0; n_bad = 0;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    backpressure = 1'b0; queue_level = '0;

    // seg 0: full-rate drain, 2 per 4 steady state, then throttle and recovery
    //   seg rs iv id  or bp ql | ov od  ir md tok cnt
    v(0, 1, 1,  0, 1, 0, 0,  0,  0, 1, 0, 8, 0);
    v(0, 1, 1,  1, 1, 0, 0,  1,  0, 1, 0, 8, 1);
    v(0, 1, 1,  2, 1, 0, 0,  1,  1, 1, 0, 7, 1);
    v(0, 1, 1,  3, 1, 0, 0,  1,  2, 1, 0, 6, 1);
    v(0, 1, 1,  4, 1, 0, 0,  1,  3, 1, 0, 7, 1);
    v(0, 1, 1,  5, 1, 0, 0,  1,  4, 1, 0, 6, 1);
    v(0, 1, 1,  6, 1, 0, 0,  1,  5, 1, 0, 5, 1);
    v(0, 1, 1,  7, 1, 0, 0,  1,  6, 1, 0, 4, 1);
    v(0, 1, 1,  8, 1, 0, 0,  1,  7, 1, 0, 5, 1);
    v(0, 1, 1,  9, 1, 0, 0,  1,  8, 1, 0, 4, 1);
    v(0, 1, 1, 10, 1, 0, 0,  1,  9, 1, 0, 3, 1);
    v(0, 1, 1, 11, 1, 0, 0,  1, 10, 1, 0, 2, 1);
    v(0, 1, 1, 12, 1, 0, 0,  1, 11, 1, 0, 3, 1);
    v(0, 1, 1, 13, 1, 0, 0,  1, 12, 1, 0, 2, 1);
    v(0, 1, 1, 14, 1, 0, 0,  1, 13, 1, 0, 1, 1);
    v(0, 1, 1, 15, 1, 0, 0,  0,  0, 1, 0, 0, 1);
    v(0, 1, 1, 16, 1, 0, 0,  1, 14, 1, 0, 2, 2);
    v(0, 1, 1, 17, 1, 0, 0,  1, 15, 1, 0, 1, 2);
    v(0, 1, 1, 18, 1, 0, 0,  0,  0, 1, 0, 0, 2);
    v(0, 1, 1, 19, 1, 0, 0,  0,  0, 1, 0, 0, 3);
    v(0, 1, 1, 20, 1, 0, 0,  1, 16, 0, 0, 2, 4);
    v(0, 1, 1, 20, 1, 0, 0,  1, 17, 1, 0, 1, 3);
    v(0, 1, 1, 21, 1, 0, 0,  0,  0, 1, 0, 0, 3);
    v(0, 1, 1, 22, 1, 0, 0,  0,  0, 0, 0, 0, 4);
    v(0, 1, 1, 22, 1, 1, 0,  1, 18, 0, 0, 2, 4);
    v(0, 1, 1, 22, 1, 0, 0,  1, 19, 1, 1, 1, 3);
    v(0, 1, 1, 23, 1, 0, 0,  0,  0, 1, 1, 0, 3);
    v(0, 1, 1, 24, 1, 0, 0,  0,  0, 0, 1, 0, 4);
    v(0, 1, 1, 24, 1, 0, 0,  1, 20, 0, 1, 1, 4);
    v(0, 1, 1, 24, 1, 0, 0,  0,  0, 1, 1, 0, 3);
    v(0, 1, 1, 25, 1, 0, 0,  0,  0, 0, 1, 0, 4);
    v(0, 1, 1, 25, 1, 0, 0,  0,  0, 0, 1, 0, 4);
    v(0, 1, 1, 25, 1, 0, 0,  1, 21, 0, 1, 1, 4);
    v(0, 1, 1, 25, 1, 0, 0,  0,  0, 1, 1, 0, 3);
    v(0, 1, 1, 26, 1, 0, 0,  0,  0, 0, 1, 0, 4);
    v(0, 1, 1, 26, 1, 1, 0,  0,  0, 0, 1, 0, 4);
    v(0, 1, 1, 26, 1, 0, 0,  1, 22, 0, 1, 1, 4);
    v(0, 1, 1, 26, 1, 0, 0,  0,  0, 1, 1, 0, 3);
    v(0, 1, 1, 27, 1, 0, 0,  0,  0, 0, 1, 0, 4);
    v(0, 1, 1, 27, 1, 0, 0,  0,  0, 0, 1, 0, 4);
    v(0, 1, 1, 27, 1, 0, 0,  1, 23, 0, 1, 1, 4);
    v(0, 1, 1, 27, 1, 0, 0,  0,  0, 1, 1, 0, 3);
    v(0, 1, 1, 28, 1, 0, 0,  0,  0, 0, 1, 0, 4);
    v(0, 1, 1, 28, 1, 0, 0,  0,  0, 0, 1, 0, 4);
    v(0, 1, 1, 28, 1, 0, 0,  1, 24, 0, 1, 1, 4);
    v(0, 1, 1, 28, 1, 0, 0,  0,  0, 1, 1, 0, 3);
    v(0, 1, 1, 29, 1, 0, 0,  0,  0, 0, 1, 0, 4);
    v(0, 1, 1, 29, 1, 0, 0,  0,  0, 0, 1, 0, 4);
    v(0, 1, 1, 29, 1, 0, 0,  1, 25, 0, 1, 1, 4);
    v(0, 1, 1, 29, 1, 0, 0,  0,  0, 1, 1, 0, 3);
    v(0, 1, 1, 30, 1, 0, 0,  0,  0, 0, 1, 0, 4);
    v(0, 1, 1, 30, 1, 0, 0,  0,  0, 0, 1, 0, 4);
    v(0, 1, 1, 30, 1, 0, 0,  1, 26, 0, 0, 1, 4);
    // seg 1: HOLD with a committed beat in flight, exit below half the limit
    v(1, 1, 1, 100, 0, 0,  0,  0,   0, 1, 0, 8, 0);
    v(1, 1, 1, 101, 0, 0, 32,  1, 100, 1, 0, 8, 1);
    v(1, 1, 0,   0, 0, 0, 32,  1, 100, 1, 2, 8, 2);
    v(1, 1, 0,   0, 1, 0, 32,  1, 100, 1, 2, 8, 2);
    v(1, 1, 0,   0, 1, 0, 32,  0,   0, 1, 2, 7, 1);
    v(1, 1, 0,   0, 1, 0, 16,  0,   0, 1, 2, 7, 1);
    v(1, 1, 0,   0, 1, 0, 15,  0,   0, 1, 2, 7, 1);
    v(1, 1, 0,   0, 1, 0, 15,  1, 101, 1, 1, 7, 1);
    v(1, 1, 0,   0, 1, 0, 15,  0,   0, 1, 1, 7, 0);
    // seg 2: fill to full, push+pop at count 3, ordering across wrap
    v(2, 1, 1, 200, 0, 0, 0,  0,   0, 1, 0, 8, 0);
    v(2, 1, 1, 201, 0, 0, 0,  1, 200, 1, 0, 8, 1);
    v(2, 1, 1, 202, 0, 0, 0,  1, 200, 1, 0, 8, 2);
    v(2, 1, 1, 203, 0, 0, 0,  1, 200, 1, 0, 8, 3);
    v(2, 1, 1, 204, 0, 0, 0,  1, 200, 0, 0, 8, 4);
    v(2, 1, 1, 204, 1, 0, 0,  1, 200, 0, 0, 8, 4);
    v(2, 1, 1, 204, 1, 0, 0,  1, 201, 1, 0, 7, 3);
    v(2, 1, 1, 205, 1, 0, 0,  1, 202, 1, 0, 6, 3);
    v(2, 1, 0,   0, 0, 0, 0,  1, 203, 1, 0, 7, 3);
    v(2, 1, 0,   0, 1, 0, 0,  1, 203, 1, 0, 7, 3);
    v(2, 1, 0,   0, 1, 0, 0,  1, 204, 1, 0, 6, 2);
    v(2, 1, 0,   0, 1, 0, 0,  1, 205, 1, 0, 5, 1);
    v(2, 1, 0,   0, 1, 0, 0,  0,   0, 1, 0, 6, 0);
    // seg 3: reset mid-stream with three beats buffered in THROTTLE
    v(3, 1, 1, 300, 0, 1, 0,  0,   0, 1, 0, 8, 0);
    v(3, 1, 1, 301, 0, 0, 0,  1, 300, 1, 1, 8, 1);
    v(3, 1, 1, 302, 0, 0, 0,  1, 300, 1, 1, 8, 2);
    v(3, 0, 0,   0, 0, 0, 0,  1, 300, 1, 1, 8, 3);
    v(3, 1, 0,   0, 0, 0, 0,  0,   0, 1, 0, 8, 0);
    v(3, 1, 0,   0, 0, 0, 0,  0,   0, 1, 0, 8, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      if (i == 0 || vecs[i].seg != vecs[i-1].seg) do_reset();
      @(negedge clk);
      rst_n        = vecs[i].rst_n;
      in_valid     = vecs[i].iv;
      in_data      = vecs[i].id;
      out_ready    = vecs[i].ordy;
      backpressure = vecs[i].bp;
      queue_level  = vecs[i].ql;
      #1;
      n_vec++;
      chk("out_valid",  i, 32'(out_valid),  32'(vecs[i].e_ov));
      chk("in_ready",   i, 32'(in_ready),   32'(vecs[i].e_ir));
      chk("mode",       i, 32'(mode),       32'(vecs[i].e_mode));
      chk("tokens",     i, 32'(tokens),     32'(vecs[i].e_tok));
      chk("fifo_count", i, 32'(fifo_count), 32'(vecs[i].e_cnt));
      if (vecs[i].e_ov) chk("out_data", i, 32'(out_data), 32'(vecs[i].e_od));
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
